// File: rtl/sample_stream_pipe.sv
// Valid/ready stream stage: per-word pass/add/subtract/invert feeding a DEPTH-entry result FIFO.
// Optional statistics counters are enabled with `define SAMPLE_STREAM_PIPE_STATS_EN.
module sample_stream_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              cfg_mode,
    input  logic [DATA_WIDTH-1:0]   cfg_operand,
    input  logic [DATA_WIDTH-1:0]   stream_in_data,
    input  logic                    stream_in_valid,
    output logic                    stream_in_ready,
    output logic [DATA_WIDTH-1:0]   stream_out_data,
    output logic                    stream_out_wrap,
    output logic                    stream_out_valid,
    input  logic                    stream_out_ready,
    output logic [$clog2(DEPTH):0]  fill_level
`ifdef SAMPLE_STREAM_PIPE_STATS_EN
    ,
    output logic [31:0]             stat_accepted,
    output logic [15:0]             stat_wraps
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_wrap;
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_inReady;

    logic                  w_accept;
    logic                  w_transfer;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_resultWrap;
    logic [CW-1:0]         w_countNext;

    assign w_accept   = stream_in_valid && r_inReady;
    assign w_transfer = stream_out_ready && (r_count != '0);

    // The extra top bit of the sum/difference is the carry or the borrow.
    always_comb begin
        w_sum        = {1'b0, stream_in_data} + {1'b0, cfg_operand};
        w_diff       = {1'b0, stream_in_data} - {1'b0, cfg_operand};
        w_result     = stream_in_data;
        w_resultWrap = 1'b0;
        case (cfg_mode)
            2'b01:   {w_resultWrap, w_result} = w_sum;
            2'b10:   {w_resultWrap, w_result} = w_diff;
            2'b11:   w_result = ~stream_in_data;
            default: ;
        endcase
    end

    always_comb begin
        w_countNext = r_count;
        case ({w_accept, w_transfer})
            2'b10:   w_countNext = r_count + CW'(1);
            2'b01:   w_countNext = r_count - CW'(1);
            default: ;
        endcase
    end

    // Storage is cleared on reset so the head output is never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_wrap <= '0;
        end else if (w_accept) begin
            r_data[r_wptr] <= w_result;
            r_wrap[r_wptr] <= w_resultWrap;
        end
    end

    // Ready is registered from the next fill level, so it stays low through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_inReady <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_transfer) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count   <= w_countNext;
            r_inReady <= (w_countNext != CW'(DEPTH));
        end
    end

    assign stream_in_ready  = r_inReady;
    assign stream_out_valid = (r_count != '0);
    assign stream_out_data  = r_data[r_rptr];
    assign stream_out_wrap  = r_wrap[r_rptr];
    assign fill_level       = r_count;

`ifdef SAMPLE_STREAM_PIPE_STATS_EN
    logic [31:0] r_statAccepted;
    logic [15:0] r_statWraps;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_statAccepted <= '0;
            r_statWraps    <= '0;
        end else if (w_accept) begin
            r_statAccepted <= r_statAccepted + 32'd1;
            if (w_resultWrap && (r_statWraps != 16'hFFFF)) begin
                r_statWraps <= r_statWraps + 16'd1;
            end
        end
    end

    assign stat_accepted = r_statAccepted;
    assign stat_wraps    = r_statWraps;
`endif

endmodule

// File: tb/tb_sample_stream_pipe.sv
// Scoreboard bench for sample_stream_pipe: directed words with hand-computed results,
// checked in order by an independent output monitor.
module tb_sample_stream_pipe;

    logic        clk;
    logic        rst_n;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_operand;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_wrap;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fill_level;
`ifdef SAMPLE_STREAM_PIPE_STATS_EN
    logic [31:0] stat_accepted;
    logic [15:0] stat_wraps;
`endif

    int total = 0;
    int bad   = 0;
    logic [16:0] expQ [$];
    logic randomStall = 1'b0;

    sample_stream_pipe #(.DATA_WIDTH(16), .DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_mode         (cfg_mode),
        .cfg_operand      (cfg_operand),
        .stream_in_data   (in_data),
        .stream_in_valid  (in_valid),
        .stream_in_ready  (in_ready),
        .stream_out_data  (out_data),
        .stream_out_wrap  (out_wrap),
        .stream_out_valid (out_valid),
        .stream_out_ready (out_ready),
        .fill_level       (fill_level)
`ifdef SAMPLE_STREAM_PIPE_STATS_EN
        ,
        .stat_accepted    (stat_accepted),
        .stat_wraps       (stat_wraps)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and bounds the fill level.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("fill_le_depth", 32'(fill_level <= 3'd4), 32'd1);
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", {15'd0, out_wrap, out_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [16:0] e;
                    e = expQ.pop_front();
                    checkOutput("out_data", 32'(out_data), 32'(e[15:0]));
                    checkOutput("out_wrap", 32'(out_wrap), 32'(e[16]));
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (randomStall) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic applyStimulus(input logic [15:0] data, input logic [15:0] expData,
                                 input logic expWrap, input bit doPush);
        bit accepted = 1'b0;
        in_data  = data;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                if (doPush) expQ.push_back({expWrap, expData});
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drainWait();
        int n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("drain_remaining", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_mode    = 2'b00;
        cfg_operand = 16'h0000;
        in_data     = 16'h0000;
        in_valid    = 1'b0;
        out_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_wrap", 32'(out_wrap), 32'd0);
        checkOutput("rst_fill", 32'(fill_level), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("ready_after_edge", 32'(in_ready), 32'd1);
        checkOutput("empty_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Pass mode and one-cycle latency
        applyStimulus(16'h1234, 16'h1234, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("latency_valid", 32'(out_valid), 32'd1);
        checkOutput("latency_fill", 32'(fill_level), 32'd1);
        drainWait();

        cfg_mode = 2'b01; cfg_operand = 16'h0001;
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b1);
        applyStimulus(16'h0010, 16'h0011, 1'b0, 1'b1);
        cfg_mode = 2'b10; cfg_operand = 16'h0005;
        applyStimulus(16'h0003, 16'hFFFE, 1'b1, 1'b1);
        cfg_mode = 2'b11;
        applyStimulus(16'h00FF, 16'hFF00, 1'b0, 1'b1);
        drainWait();

        // Stalled sink fills the FIFO; the fifth word must be refused
        cfg_mode  = 2'b00;
        out_ready = 1'b0;
        applyStimulus(16'h0A01, 16'h0A01, 1'b0, 1'b1);
        applyStimulus(16'h0A02, 16'h0A02, 1'b0, 1'b1);
        applyStimulus(16'h0A03, 16'h0A03, 1'b0, 1'b1);
        applyStimulus(16'h0A04, 16'h0A04, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("full_fill", 32'(fill_level), 32'd4);
        checkOutput("full_ready", 32'(in_ready), 32'd0);
        in_data  = 16'hBEEF;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("full_fill_held", 32'(fill_level), 32'd4);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("ready_after_transfer", 32'(in_ready), 32'd1);
        checkOutput("fill_after_transfer", 32'(fill_level), 32'd3);
        drainWait();

        // Random sink stalls with mode changes between words
        randomStall = 1'b1;
        cfg_mode = 2'b01; cfg_operand = 16'h0100;
        applyStimulus(16'h0050, 16'h0150, 1'b0, 1'b1);
        applyStimulus(16'hFF80, 16'h0080, 1'b1, 1'b1);
        cfg_mode = 2'b10; cfg_operand = 16'h0010;
        applyStimulus(16'h0008, 16'hFFF8, 1'b1, 1'b1);
        applyStimulus(16'h0020, 16'h0010, 1'b0, 1'b1);
        cfg_mode = 2'b11;
        applyStimulus(16'hA5A5, 16'h5A5A, 1'b0, 1'b1);
        cfg_mode = 2'b00;
        applyStimulus(16'h7777, 16'h7777, 1'b0, 1'b1);
        cfg_mode = 2'b01; cfg_operand = 16'h0003;
        applyStimulus(16'h1000, 16'h1003, 1'b0, 1'b1);
        randomStall = 1'b0;
        out_ready   = 1'b1;
        drainWait();

        // Reset with three words stored: they must never appear
        out_ready = 1'b0;
        cfg_mode  = 2'b00;
        applyStimulus(16'hDEAD, 16'h0000, 1'b0, 1'b0);
        applyStimulus(16'hDEAE, 16'h0000, 1'b0, 1'b0);
        applyStimulus(16'hDEAF, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pre_reset_fill", 32'(fill_level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_out_data", 32'(out_data), 32'd0);
        checkOutput("midrst_out_wrap", 32'(out_wrap), 32'd0);
        checkOutput("midrst_fill", 32'(fill_level), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);
        applyStimulus(16'h4242, 16'h4242, 1'b0, 1'b1);
        drainWait();

`ifdef SAMPLE_STREAM_PIPE_STATS_EN
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cfg_mode = 2'b01; cfg_operand = 16'h8000;
        applyStimulus(16'h8000, 16'h0000, 1'b1, 1'b1);
        applyStimulus(16'h8000, 16'h0000, 1'b1, 1'b1);
        applyStimulus(16'h8000, 16'h0000, 1'b1, 1'b1);
        drainWait();
        checkOutput("stat_accepted", stat_accepted, 32'd3);
        checkOutput("stat_wraps", 32'(stat_wraps), 32'd3);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
